// File: rtl/wb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : wb_mem_responder
// Description : Pipelined Wishbone B4 slave backed by an on-chip word RAM.
//               Every accepted request is acknowledged a fixed number of
//               cycles later, in order, through a small outstanding-request
//               queue. The queue provides stall backpressure and is flushed
//               when the master drops cyc_i.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_mem_responder #(
    parameter int AWIDTH  = 10,
    parameter int LATENCY = 2,
    parameter int DEPTH   = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] adr_i,
    input  logic        cyc_i,
    input  logic        stb_i,
    input  logic        we_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] dat_i,
    output logic        ack_o,
    output logic        stall_o,
    output logic [31:0] dat_o
);

    localparam int                c_PTRW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                c_CNTW    = c_PTRW + 1;
    localparam logic [3:0]        c_CD_INIT = 4'(LATENCY - 1);
    localparam logic [c_CNTW-1:0] c_DEPTH   = c_CNTW'(DEPTH);
    localparam logic [c_CNTW-1:0] c_CNT_ONE = c_CNTW'(1);
    localparam logic [c_CNTW-1:0] c_CNT_ZRO = '0;
    localparam logic [c_PTRW-1:0] c_PTR_ONE = c_PTRW'(1);
    // With a single cycle of latency the ack is issued on the accept edge
    // itself, so requests never sit in the queue.
    localparam logic              c_BYPASS  = (LATENCY == 1) ? 1'b1 : 1'b0;

    // Backing store; intentionally not reset so contents survive rst_i.
    logic [31:0]       mem_q [2**AWIDTH];

    // Outstanding-request queue.
    logic [c_PTRW-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_PTRW-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_CNTW-1:0] count_q, count_d;
    logic [3:0]        cd_q [DEPTH];
    logic [3:0]        cd_d [DEPTH];
    logic              ent_we_q [DEPTH];
    logic [31:0]       ent_dat_q [DEPTH];

    logic              ack_q, ack_d;
    logic [31:0]       dat_q;

    logic [AWIDTH-1:0] w_idx;
    logic              w_accept;
    logic              w_enq;
    logic              w_pop;
    logic              w_bypass;
    logic              w_unused_adr;

    assign w_idx        = adr_i[AWIDTH+1:2];
    assign w_unused_adr = ^{adr_i[31:AWIDTH+2], adr_i[1:0]};

    // No same-cycle pop bypass: a full queue stalls even if it acks now.
    assign stall_o  = (count_q == c_DEPTH);
    assign w_accept = rst_i & cyc_i & stb_i & ~stall_o;
    assign w_bypass = c_BYPASS & w_accept;
    assign w_enq    = ~c_BYPASS & w_accept;
    // The head entry is due when its countdown would reach zero on this edge.
    assign w_pop    = cyc_i && (count_q != c_CNT_ZRO) && (cd_q[rd_ptr_q] == 4'd1);

    assign ack_o = ack_q;
    assign dat_o = dat_q;

    // Next-state for queue pointers, occupancy, countdowns and the ack flag.
    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        ack_d    = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            cd_d[i] = (cd_q[i] != 4'd0) ? (cd_q[i] - 4'd1) : 4'd0;
        end

        if (!cyc_i) begin
            // Cycle abort: drop every pending request without acking it.
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            for (int i = 0; i < DEPTH; i++) begin
                cd_d[i] = 4'd0;
            end
        end else begin
            if (w_enq) begin
                cd_d[wr_ptr_q] = c_CD_INIT;
                wr_ptr_d       = wr_ptr_q + c_PTR_ONE;
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + c_PTR_ONE;
            end
            ack_d   = w_pop | w_bypass;
            count_d = count_q + (w_enq ? c_CNT_ONE : c_CNT_ZRO)
                              - (w_pop ? c_CNT_ONE : c_CNT_ZRO);
        end
    end

    // Control state register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            ack_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                cd_q[i] <= 4'd0;
            end
        end else begin
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            ack_q    <= ack_d;
            for (int i = 0; i < DEPTH; i++) begin
                cd_q[i] <= cd_d[i];
            end
        end
    end

    // Byte-masked RAM write at the accept edge.
    always_ff @(posedge clk_i) begin
        if (w_accept && we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (sel_i[b]) begin
                    mem_q[w_idx][8*b +: 8] <= dat_i[8*b +: 8];
                end
            end
        end
    end

    // Capture request type and read data into the queue; the RAM read at the
    // accept edge returns the word as left by all previously accepted writes.
    always_ff @(posedge clk_i) begin
        if (w_enq) begin
            ent_we_q[wr_ptr_q]  <= we_i;
            ent_dat_q[wr_ptr_q] <= we_i ? 32'd0 : mem_q[w_idx];
        end
    end

    // Read-data output: updated only when acking, zero for write acks.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            dat_q <= 32'd0;
        end else if (w_bypass) begin
            dat_q <= we_i ? 32'd0 : mem_q[w_idx];
        end else if (w_pop) begin
            dat_q <= ent_we_q[rd_ptr_q] ? 32'd0 : ent_dat_q[rd_ptr_q];
        end
    end

endmodule
`default_nettype wire
